// File: rtl/dsp_ctrl_pkg.sv
// Shared types and constants for the DSP mode controller.
package dsp_ctrl_pkg;

  // Width of one audio sample on both the DSP and codec sides.
  localparam int SAMPLE_W = 16;

  // Values driven on the DSP subsystem selector.
  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_FIR    = 2'b01;
  localparam logic [1:0] MODE_ECHO   = 2'b10;

  // Mode-switch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FADE_OUT = 2'b01,
    ST_SETTLE   = 2'b10,
    ST_FADE_IN  = 2'b11
  } state_t;

endpackage

// File: rtl/gain_ramp_scaler.sv
// Applies the fade gain g/L to one sample per clock and registers the result.
// Unity gain (g = L) passes the sample straight through.
module gain_ramp_scaler
  import dsp_ctrl_pkg::*;
#(
  parameter int RAMP_LOG2 = 4
) (
  input  logic                  sample_clock,
  input  logic                  reset,
  input  logic [SAMPLE_W-1:0]   sample,
  input  logic [RAMP_LOG2:0]    g,
  output logic [SAMPLE_W-1:0]   line_sample
);

  localparam int                PROD_W = SAMPLE_W + 1 + RAMP_LOG2;
  localparam int                G_W    = RAMP_LOG2 + 1;
  localparam logic [G_W-1:0]    G_FULL = G_W'(1'b1) << RAMP_LOG2;

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] product;
  logic [SAMPLE_W-1:0]      scaled;

  // Signed multiply by g, then arithmetic shift (rounds toward minus infinity).
  always_comb begin
    sample_ext = {{(PROD_W - SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
    gain_ext   = {{(PROD_W - G_W){1'b0}}, g};
    product    = sample_ext * gain_ext;
    if (g == G_FULL) begin
      scaled = sample;
    end else begin
      scaled = SAMPLE_W'(product >>> RAMP_LOG2);
    end
  end

  // Output register toward the codec.
  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      line_sample <= {SAMPLE_W{1'b0}};
    end else begin
      line_sample <= scaled;
    end
  end

endmodule

// File: rtl/dsp_mode_controller.sv
// Sequences DSP mode changes: fade out, switch selector, let the FIR/echo
// pipelines flush while muted, fade back in.
// Build option: define DSP_MODE_CTRL_SOFT_SWITCH_EN for the faded switch;
// without it requests switch the selector immediately at unity gain.
module dsp_mode_controller
  import dsp_ctrl_pkg::*;
#(
  parameter int RAMP_LOG2      = 4,
  parameter int SETTLE_SAMPLES = 16
) (
  input  logic        sample_clock,
  input  logic        reset,
  input  logic        mode_req,
  input  logic [1:0]  mode_sel,
  input  logic [15:0] dsp_sample,
  output logic [1:0]  selector,
  output logic [15:0] line_sample,
  output logic        busy
);

  localparam int             G_W    = RAMP_LOG2 + 1;
  localparam logic [G_W-1:0] G_FULL = G_W'(1'b1) << RAMP_LOG2;

  logic [G_W-1:0] g;
  logic [1:0]     selector_next;

`ifdef DSP_MODE_CTRL_SOFT_SWITCH_EN
  localparam int               CNT_W       = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
  localparam logic [G_W-1:0]   G_ZERO      = G_W'(1'b0);
  localparam logic [G_W-1:0]   G_ONE       = G_W'(1'b1);
  localparam logic [G_W-1:0]   G_LAST      = G_FULL - G_ONE;

  state_t          state;
  state_t          next_state;
  logic [G_W-1:0]  g_next;
  logic [1:0]      target;
  logic [1:0]      target_next;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] settle_cnt_next;
  logic            pend_valid;
  logic            pend_valid_next;
  logic [1:0]      pend_sel;
  logic [1:0]      pend_sel_next;
  logic            live_req;
  logic            pend_ready;
  logic            start_switch;
  logic [1:0]      start_sel;

  // Request qualification. A pending entry is only looked at once busy has
  // dropped, i.e. one full idle cycle after the fade-in completes.
  always_comb begin
    live_req     = mode_req && (mode_sel != selector);
    pend_ready   = !mode_req && pend_valid && !busy;
    start_switch = live_req || (pend_ready && (pend_sel != selector));
    if (mode_req) begin
      start_sel = mode_sel;
    end else begin
      start_sel = pend_sel;
    end
  end

  // State register.
  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_switch) next_state = ST_FADE_OUT;
        else              next_state = ST_IDLE;
      end
      ST_FADE_OUT: begin
        if (g == G_ZERO) next_state = ST_SETTLE;
        else             next_state = ST_FADE_OUT;
      end
      ST_SETTLE: begin
        if (!live_req && (settle_cnt == CNT_ZERO)) next_state = ST_FADE_IN;
        else                                        next_state = ST_SETTLE;
      end
      ST_FADE_IN: begin
        if (g == G_LAST) next_state = ST_IDLE;
        else             next_state = ST_FADE_IN;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Per-state updates of gain, selector, settle counter, target and pending slot.
  always_comb begin
    g_next          = g;
    target_next     = target;
    selector_next   = selector;
    settle_cnt_next = settle_cnt;
    pend_valid_next = pend_valid;
    pend_sel_next   = pend_sel;
    case (state)
      ST_IDLE: begin
        g_next = G_FULL;
        // Any live request discards the pending entry; otherwise it is consumed here.
        if (mode_req || pend_ready) begin
          pend_valid_next = 1'b0;
        end else begin
          pend_valid_next = pend_valid;
        end
        if (start_switch) begin
          target_next = start_sel;
        end else begin
          target_next = target;
        end
      end
      ST_FADE_OUT: begin
        if (mode_req) begin
          target_next = mode_sel;
        end else begin
          target_next = target;
        end
        if (g == G_ZERO) begin
          selector_next   = target_next;
          settle_cnt_next = SETTLE_LOAD;
        end else begin
          g_next = g - G_ONE;
        end
      end
      ST_SETTLE: begin
        g_next = G_ZERO;
        if (live_req) begin
          selector_next   = mode_sel;
          target_next     = mode_sel;
          settle_cnt_next = SETTLE_LOAD;
        end else if (settle_cnt != CNT_ZERO) begin
          settle_cnt_next = settle_cnt - CNT_ONE;
        end else begin
          g_next = G_ONE;
        end
      end
      ST_FADE_IN: begin
        g_next = g + G_ONE;
        if (mode_req) begin
          pend_valid_next = 1'b1;
          pend_sel_next   = mode_sel;
        end else begin
          pend_valid_next = pend_valid;
          pend_sel_next   = pend_sel;
        end
      end
      default: begin
        g_next = G_FULL;
      end
    endcase
  end

  // Datapath registers; busy mirrors the previous cycle's state.
  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      g          <= G_FULL;
      target     <= MODE_BYPASS;
      settle_cnt <= CNT_ZERO;
      pend_valid <= 1'b0;
      pend_sel   <= MODE_BYPASS;
      busy       <= 1'b0;
    end else begin
      g          <= g_next;
      target     <= target_next;
      settle_cnt <= settle_cnt_next;
      pend_valid <= pend_valid_next;
      pend_sel   <= pend_sel_next;
      busy       <= (state != ST_IDLE);
    end
  end
`else
  // Hard switch: accepted requests retarget the subsystem on the next edge.
  always_comb begin
    if (mode_req) begin
      selector_next = mode_sel;
    end else begin
      selector_next = selector;
    end
  end

  assign g    = G_FULL;
  assign busy = 1'b0;
`endif

  // Selector register driven to the DSP subsystem.
  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      selector <= MODE_BYPASS;
    end else begin
      selector <= selector_next;
    end
  end

  gain_ramp_scaler #(
    .RAMP_LOG2 (RAMP_LOG2)
  ) u_scaler (
    .sample_clock (sample_clock),
    .reset        (reset),
    .sample       (dsp_sample),
    .g            (g),
    .line_sample  (line_sample)
  );

endmodule

// File: tb/tb_dsp_mode_controller.sv
// Self-checking bench for dsp_mode_controller (default parameters L=16, S=16).
// Follows DSP_MODE_CTRL_SOFT_SWITCH_EN: faded-switch expectations when defined,
// hard-switch expectations otherwise.
module tb_dsp_mode_controller;

  logic        sample_clock;
  logic        reset;
  logic        mode_req;
  logic [1:0]  mode_sel;
  logic [15:0] dsp_sample;
  logic [1:0]  selector;
  logic [15:0] line_sample;
  logic        busy;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic        req;
    logic [1:0]  sel;
    logic [15:0] smp;
    logic [1:0]  exp_sel;
    logic [15:0] exp_line;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [6];

  dsp_mode_controller dut (
    .sample_clock (sample_clock),
    .reset        (reset),
    .mode_req     (mode_req),
    .mode_sel     (mode_sel),
    .dsp_sample   (dsp_sample),
    .selector     (selector),
    .line_sample  (line_sample),
    .busy         (busy)
  );

  initial sample_clock = 1'b0;
  always #5 sample_clock = ~sample_clock;

  task automatic tick();
    @(posedge sample_clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks_total++;
    if (act == exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // (sample * g) >>> 4 as a 16-bit pattern.
  function automatic int scale(input logic [15:0] s, input int gain);
    int p;
    p = int'($signed(s)) * gain;
    return (p >>> 4) & 32'h0000FFFF;
  endfunction

  // Gain after edge t+k for an uninterrupted switch requested at edge t.
  function automatic int exp_g(input int k);
    if (k <= 0)       return 16;
    else if (k <= 16) return 16 - k;
    else if (k <= 32) return 0;
    else if (k <= 48) return k - 32;
    else              return 16;
  endfunction

  // Gain when the settle phase is restarted by a request at edge t+20.
  function automatic int exp_g_settle(input int k);
    if (k <= 16)      return exp_g(k);
    else if (k <= 35) return 0;
    else if (k <= 51) return k - 35;
    else              return 16;
  endfunction

  task automatic full_switch(input logic [1:0] from_sel, input logic [1:0] to_sel,
                             input logic [15:0] smp);
    dsp_sample = smp;
    mode_sel   = to_sel;
    mode_req   = 1'b1;
    tick();
    mode_req = 1'b0;
    chk("sw_accept_busy", 32'(busy), 0);
    chk("sw_accept_line", 32'(line_sample), 32'(smp));
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk("sw_line", 32'(line_sample), scale(smp, exp_g(k - 1)));
      chk("sw_sel", 32'(selector), (k >= 17) ? 32'(to_sel) : 32'(from_sel));
      chk("sw_busy", 32'(busy), (k <= 48) ? 1 : 0);
    end
  endtask

  initial begin
    reset      = 1'b0;
    mode_req   = 1'b0;
    mode_sel   = 2'b00;
    dsp_sample = 16'h0000;

`ifdef DSP_MODE_CTRL_SOFT_SWITCH_EN
    vecs[0] = '{1'b0, 2'b00, 16'h1234, 2'b00, 16'h1234, 1'b0};
    vecs[1] = '{1'b1, 2'b00, 16'h1234, 2'b00, 16'h1234, 1'b0};
    vecs[2] = '{1'b0, 2'b11, 16'h8000, 2'b00, 16'h8000, 1'b0};
    vecs[3] = '{1'b0, 2'b01, 16'h7FFF, 2'b00, 16'h7FFF, 1'b0};
    vecs[4] = '{1'b1, 2'b00, 16'hFFFF, 2'b00, 16'hFFFF, 1'b0};
    vecs[5] = '{1'b0, 2'b10, 16'h0001, 2'b00, 16'h0001, 1'b0};
`else
    vecs[0] = '{1'b0, 2'b00, 16'h1234, 2'b00, 16'h1234, 1'b0};
    vecs[1] = '{1'b1, 2'b00, 16'h5555, 2'b00, 16'h5555, 1'b0};
    vecs[2] = '{1'b1, 2'b01, 16'h8000, 2'b01, 16'h8000, 1'b0};
    vecs[3] = '{1'b0, 2'b10, 16'h7FFF, 2'b01, 16'h7FFF, 1'b0};
    vecs[4] = '{1'b1, 2'b10, 16'hFFFF, 2'b10, 16'hFFFF, 1'b0};
    vecs[5] = '{1'b1, 2'b00, 16'hABCD, 2'b00, 16'hABCD, 1'b0};
`endif

    // Reset values.
    tick();
    tick();
    chk("rst_sel", 32'(selector), 0);
    chk("rst_line", 32'(line_sample), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;

    // Table-driven idle behaviour.
    for (int i = 0; i < 6; i++) begin
      mode_req   = vecs[i].req;
      mode_sel   = vecs[i].sel;
      dsp_sample = vecs[i].smp;
      tick();
      chk("vec_sel", 32'(selector), 32'(vecs[i].exp_sel));
      chk("vec_line", 32'(line_sample), 32'(vecs[i].exp_line));
      chk("vec_busy", 32'(busy), 32'(vecs[i].exp_busy));
    end
    mode_req = 1'b0;

`ifdef DSP_MODE_CTRL_SOFT_SWITCH_EN
    // Full switch with a constant positive sample, then one with -1.
    full_switch(2'b00, 2'b01, 16'h4000);
    full_switch(2'b01, 2'b00, 16'hFFFF);

    // Retarget during fade-out: 01 at t, 10 at t+5.
    dsp_sample = 16'h4000;
    mode_sel   = 2'b01;
    mode_req   = 1'b1;
    tick();
    for (int k = 1; k <= 50; k++) begin
      if (k == 5) begin
        mode_req = 1'b1;
        mode_sel = 2'b10;
      end else begin
        mode_req = 1'b0;
      end
      tick();
      chk("rt_sel", 32'(selector), (k >= 17) ? 2 : 0);
      chk("rt_line", 32'(line_sample), scale(16'h4000, exp_g(k - 1)));
      chk("rt_busy", 32'(busy), (k <= 48) ? 1 : 0);
    end

    // Pending request during fade-in: 01 at t, 10 at t+40.
    dsp_sample = 16'h2000;
    mode_sel   = 2'b01;
    mode_req   = 1'b1;
    tick();
    for (int k = 1; k <= 100; k++) begin
      if (k == 40) begin
        mode_req = 1'b1;
        mode_sel = 2'b10;
      end else begin
        mode_req = 1'b0;
      end
      tick();
      chk("pend_sel", 32'(selector), (k < 17) ? 2 : ((k < 67) ? 1 : 2));
      chk("pend_busy", 32'(busy), ((k <= 48) || ((k >= 51) && (k <= 98))) ? 1 : 0);
      chk("pend_line", 32'(line_sample),
          scale(16'h2000, (k - 1 <= 49) ? exp_g(k - 1) : exp_g(k - 51)));
    end

    // Request during settle: 01 at t, 00 at t+20 restarts the flush.
    dsp_sample = 16'h7FFF;
    mode_sel   = 2'b01;
    mode_req   = 1'b1;
    tick();
    for (int k = 1; k <= 53; k++) begin
      if (k == 20) begin
        mode_req = 1'b1;
        mode_sel = 2'b00;
      end else begin
        mode_req = 1'b0;
      end
      tick();
      chk("settle_sel", 32'(selector), (k < 17) ? 2 : ((k < 20) ? 1 : 0));
      chk("settle_busy", 32'(busy), (k <= 51) ? 1 : 0);
      chk("settle_line", 32'(line_sample), scale(16'h7FFF, exp_g_settle(k - 1)));
    end
`endif

    // Reset mid-operation.
    dsp_sample = 16'h1234;
    mode_sel   = 2'b01;
    mode_req   = 1'b1;
    tick();
    mode_req = 1'b0;
`ifdef DSP_MODE_CTRL_SOFT_SWITCH_EN
    repeat (19) tick();
    chk("prerst_busy", 32'(busy), 1);
`else
    tick();
    chk("prerst_line", 32'(line_sample), 32'h1234);
`endif
    chk("prerst_sel", 32'(selector), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_sel", 32'(selector), 0);
    chk("async_rst_line", 32'(line_sample), 0);
    chk("async_rst_busy", 32'(busy), 0);
    #2;
    reset = 1'b1;
    tick();
    chk("post_rst_line", 32'(line_sample), 32'h1234);
    chk("post_rst_busy", 32'(busy), 0);
    repeat (20) tick();
    chk("post_rst_sel", 32'(selector), 0);
    chk("post_rst_idle", 32'(busy), 0);
    chk("post_rst_pass", 32'(line_sample), 32'h1234);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
